// File: rtl/bsg_demux_buffered.sv
// ============================================================================
//  Module      : bsg_demux_buffered
//  Description : Handshaked 1-to-els_p stream demultiplexer. One ready/valid
//                input carries a per-word lane select and fans out to els_p
//                valid/yumi lanes, each with a private 2-entry FIFO, so a
//                stalled consumer only blocks words destined for its lane.
//                Optional feature macro: BSG_DEMUX_BUFFERED_ERR_EN
//                (sticky error_o on out-of-range select, plus a warning).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

module bsg_demux_buffered #(
    parameter int width_p   = 8,
    parameter int els_p     = 2,
    parameter int lg_els_lp = `BSG_SAFE_CLOG2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     v_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [lg_els_lp-1:0]     sel_i,
    output logic                     ready_o,
    output logic [els_p-1:0]         v_o,
    output logic [els_p*width_p-1:0] data_o,
    input  logic [els_p-1:0]         yumi_i,
    output logic                     error_o
);

    logic [els_p-1:0] sel_hit;      // one-hot decode of sel_i
    logic [els_p-1:0] lane_full;    // lane holds two words
    logic             sel_in_range; // sel_i names an existing lane

    // ------------------------------------------------------------------
    // Select decode. Only a non-power-of-2 lane count can see an
    // out-of-range select; the other cases are constant in range.
    // ------------------------------------------------------------------
    if (els_p == 1) begin : g_single
        logic sel_unused;
        assign sel_unused   = ^sel_i;
        assign sel_hit      = 1'b1;
        assign sel_in_range = 1'b1;
    end else begin : g_multi
        for (genvar k = 0; k < els_p; k++) begin : g_hit
            assign sel_hit[k] = (sel_i == lg_els_lp'(k));
        end
        if ((1 << lg_els_lp) == els_p) begin : g_pow2
            assign sel_in_range = 1'b1;
        end else begin : g_npow2
            localparam logic [lg_els_lp-1:0] ELS_C = lg_els_lp'(els_p);
            assign sel_in_range = (sel_i < ELS_C);
        end
    end

    // Out-of-range words are always accepted (and dropped); in-range words
    // wait only while their own lane is full. No full-bypass on yumi.
    assign ready_o = ~sel_in_range | ~|(sel_hit & lane_full);

    // ------------------------------------------------------------------
    // Per-lane 2-entry FIFO
    // ------------------------------------------------------------------
    for (genvar k = 0; k < els_p; k++) begin : g_lane
        logic [width_p-1:0] mem [2];
        logic [1:0]         count;
        logic               wptr;
        logic               rptr;
        logic               enq;
        logic               deq;

        assign enq = v_i & ready_o & sel_in_range & sel_hit[k];
        // Gated by occupancy so an illegal yumi can never underflow count
        assign deq = yumi_i[k] & (count != 2'd0);

        assign lane_full[k] = (count == 2'd2);
        assign v_o[k]       = (count != 2'd0);
        assign data_o[k*width_p +: width_p] = mem[rptr];

        // Occupancy and pointer bookkeeping; pointers wrap modulo 2
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                count <= 2'd0;
                wptr  <= 1'b0;
                rptr  <= 1'b0;
            end else begin
                if (enq) wptr <= ~wptr;
                if (deq) rptr <= ~rptr;
                case ({enq, deq})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end

        // Storage is deliberately left unreset; v_o qualifies data_o
        always_ff @(posedge clk_i) begin
            if (enq) mem[wptr] <= data_i;
        end
    end

    // ------------------------------------------------------------------
    // Sticky out-of-range error (optional)
    // ------------------------------------------------------------------
`ifdef BSG_DEMUX_BUFFERED_ERR_EN
    logic error_r;

    // Set on any accepted out-of-range word, held until reset
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            error_r <= 1'b0;
        else if (v_i & ~sel_in_range)
            error_r <= 1'b1;
    end

    assign error_o = error_r;

`ifndef SYNTHESIS
    // Report the offending select value in simulation
    always_ff @(posedge clk_i) begin
        if (reset_n_i && v_i && !sel_in_range)
            $warning("bsg_demux_buffered: out-of-range sel_i=%0d dropped", sel_i);
    end
`endif
`else
    assign error_o = 1'b0;
`endif

`ifndef SYNTHESIS
    // A dequeue on an empty lane is a consumer protocol violation
    yumi_on_empty: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        ((yumi_i & ~v_o) == '0))
        else $error("bsg_demux_buffered: yumi_i=%b while v_o=%b", yumi_i, v_o);
`endif

endmodule

`default_nettype wire

// File: tb/tb_bsg_demux_buffered.sv
// ============================================================================
//  Module      : tb_bsg_demux_buffered
//  Description : Self-checking bench for bsg_demux_buffered: a 4-lane and a
//                3-lane instance, table-driven vectors, hand sequences and a
//                randomized run against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bsg_demux_buffered;

`ifdef BSG_DEMUX_BUFFERED_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // 4-lane instance
    logic        v4;
    logic [7:0]  d4;
    logic [1:0]  s4;
    logic        r4;
    logic [3:0]  vo4;
    logic [31:0] do4;
    logic [3:0]  y4;
    logic        e4;

    // 3-lane instance (has an out-of-range select value 3)
    logic        v3;
    logic [7:0]  d3;
    logic [1:0]  s3;
    logic        r3;
    logic [2:0]  vo3;
    logic [23:0] do3;
    logic [2:0]  y3;
    logic        e3;

    bsg_demux_buffered #(.width_p(8), .els_p(4)) dut4 (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v4), .data_i(d4), .sel_i(s4),
        .ready_o(r4), .v_o(vo4), .data_o(do4), .yumi_i(y4), .error_o(e4));

    bsg_demux_buffered #(.width_p(8), .els_p(3)) dut3 (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v3), .data_i(d3), .sel_i(s3),
        .ready_o(r3), .v_o(vo3), .data_o(do3), .yumi_i(y3), .error_o(e3));

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one FIFO queue per lane, plus the sticky error flag
    logic [7:0] m4 [4][$];
    logic [7:0] m3 [3][$];
    logic       merr3;

    task automatic do_reset();
        reset_n = 1'b0;
        v4 = 0; s4 = 0; d4 = 0; y4 = 0;
        v3 = 0; s3 = 0; d3 = 0; y3 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) m4[k].delete();
        for (int k = 0; k < 3; k++) m3[k].delete();
        merr3 = 1'b0;
    endtask

    typedef struct {
        logic       v;
        logic [1:0] sel;
        logic [7:0] data;
        logic [3:0] yumi;
        logic       exp_ready;
        logic [3:0] exp_v;
        logic       chk;
        int         lane;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl [12];

    // One cycle on the 4-lane instance: ready checked before the edge,
    // outputs checked just after it
    task automatic step4(input vec_t t, input string tag);
        logic [7:0] got;
        @(negedge clk);
        v4 = t.v; s4 = t.sel; d4 = t.data; y4 = t.yumi;
        #1 check({tag, "_ready"}, 32'(r4), 32'(t.exp_ready));
        @(posedge clk);
        #1;
        check({tag, "_v_o"}, 32'(vo4), 32'(t.exp_v));
        if (t.chk) begin
            got = do4[t.lane*8 +: 8];
            check({tag, "_data"}, 32'(got), 32'(t.exp_data));
        end
    endtask

    logic [3:0] ev4;
    logic [2:0] ev3;
    logic       er4, er3, inr3;

    initial begin
        // Basic routing, backpressure and simultaneous enqueue/dequeue
        tbl[0]  = '{1'b1, 2'd2, 8'hA1, 4'b0000, 1'b1, 4'b0100, 1'b1, 2, 8'hA1};
        tbl[1]  = '{1'b1, 2'd0, 8'hB2, 4'b0000, 1'b1, 4'b0101, 1'b1, 0, 8'hB2};
        tbl[2]  = '{1'b1, 2'd1, 8'h11, 4'b0000, 1'b1, 4'b0111, 1'b1, 1, 8'h11};
        tbl[3]  = '{1'b1, 2'd1, 8'h22, 4'b0000, 1'b1, 4'b0111, 1'b1, 1, 8'h11};
        tbl[4]  = '{1'b1, 2'd1, 8'h33, 4'b0000, 1'b0, 4'b0111, 1'b1, 1, 8'h11};
        tbl[5]  = '{1'b1, 2'd1, 8'h33, 4'b0010, 1'b0, 4'b0111, 1'b1, 1, 8'h22};
        tbl[6]  = '{1'b1, 2'd1, 8'h33, 4'b0000, 1'b1, 4'b0111, 1'b1, 1, 8'h22};
        tbl[7]  = '{1'b1, 2'd3, 8'h55, 4'b0000, 1'b1, 4'b1111, 1'b1, 3, 8'h55};
        tbl[8]  = '{1'b1, 2'd3, 8'h66, 4'b1000, 1'b1, 4'b1111, 1'b1, 3, 8'h66};
        tbl[9]  = '{1'b0, 2'd0, 8'h00, 4'b1000, 1'b1, 4'b0111, 1'b1, 1, 8'h22};
        tbl[10] = '{1'b0, 2'd0, 8'h00, 4'b0010, 1'b1, 4'b0111, 1'b1, 1, 8'h33};
        tbl[11] = '{1'b0, 2'd0, 8'h00, 4'b0111, 1'b1, 4'b0000, 1'b0, 0, 8'h00};

        do_reset();
        #1;
        check("reset_v_o4", 32'(vo4), 32'h0);
        check("reset_v_o3", 32'(vo3), 32'h0);
        check("reset_err3", 32'(e3), 32'h0);
        check("reset_ready4", 32'(r4), 32'h1);

        for (int i = 0; i < 12; i++) step4(tbl[i], $sformatf("vec%0d", i));

        // Streaming on lane 0 while lane 1 stays full and stalled
        step4('{1'b1, 2'd1, 8'hC1, 4'b0000, 1'b1, 4'b0010, 1'b1, 1, 8'hC1}, "fill1a");
        step4('{1'b1, 2'd1, 8'hC2, 4'b0000, 1'b1, 4'b0010, 1'b1, 1, 8'hC1}, "fill1b");
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            v4 = 1'b1; s4 = 2'd1; d4 = 8'hEE; y4 = 4'b0000;
            #1 check($sformatf("iso_ready_l1_%0d", i), 32'(r4), 32'h0);
            s4 = 2'd0; d4 = 8'(8'h40 + i); y4 = (i > 0) ? 4'b0001 : 4'b0000;
            #1 check($sformatf("str_ready_%0d", i), 32'(r4), 32'h1);
            @(posedge clk);
            #1;
            check($sformatf("str_v_o_%0d", i), 32'(vo4), 32'h3);
            check($sformatf("str_data_%0d", i), 32'(do4[7:0]), 32'(8'h40 + i));
            check($sformatf("str_l1_%0d", i), 32'(do4[15:8]), 32'hC1);
        end
        step4('{1'b0, 2'd0, 8'h00, 4'b0011, 1'b1, 4'b0010, 1'b1, 1, 8'hC2}, "drain_a");
        step4('{1'b0, 2'd0, 8'h00, 4'b0010, 1'b1, 4'b0000, 1'b0, 0, 8'h00}, "drain_b");

        // Out-of-range select on the 3-lane instance
        do_reset();
        @(negedge clk);
        v3 = 1'b1; s3 = 2'd3; d3 = 8'h5A; y3 = 3'b000;
        #1 check("oor_ready", 32'(r3), 32'h1);
        @(posedge clk);
        #1;
        check("oor_v_o", 32'(vo3), 32'h0);
        check("oor_err", 32'(e3), 32'(ERR_EN));
        @(negedge clk);
        v3 = 1'b1; s3 = 2'd0; d3 = 8'h3C;
        @(posedge clk);
        #1;
        check("oor_err_hold", 32'(e3), 32'(ERR_EN));
        check("oor_after_v_o", 32'(vo3), 32'h1);
        check("oor_after_data", 32'(do3[7:0]), 32'h3C);

        // Randomized traffic against the queue model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            v4 = 1'($urandom_range(0, 1)); s4 = 2'($urandom_range(0, 3)); d4 = 8'($urandom);
            for (int k = 0; k < 4; k++) y4[k] = (m4[k].size() > 0) && ($urandom_range(0, 2) != 0);
            v3 = 1'($urandom_range(0, 1)); s3 = 2'($urandom_range(0, 3)); d3 = 8'($urandom);
            for (int k = 0; k < 3; k++) y3[k] = (m3[k].size() > 0) && ($urandom_range(0, 2) != 0);
            er4  = (m4[s4].size() < 2);
            inr3 = (s3 < 2'd3);
            er3  = 1'b1;
            if (inr3) er3 = (m3[s3].size() < 2);
            #1;
            check("rnd_ready4", 32'(r4), 32'(er4));
            check("rnd_ready3", 32'(r3), 32'(er3));
            @(posedge clk);
            for (int k = 0; k < 4; k++) if (y4[k]) void'(m4[k].pop_front());
            if (v4 && er4) m4[s4].push_back(d4);
            for (int k = 0; k < 3; k++) if (y3[k]) void'(m3[k].pop_front());
            if (v3 && inr3 && er3) m3[s3].push_back(d3);
            if (v3 && !inr3 && ERR_EN) merr3 = 1'b1;
            #1;
            for (int k = 0; k < 4; k++) ev4[k] = (m4[k].size() > 0);
            for (int k = 0; k < 3; k++) ev3[k] = (m3[k].size() > 0);
            check("rnd_v_o4", 32'(vo4), 32'(ev4));
            check("rnd_v_o3", 32'(vo3), 32'(ev3));
            check("rnd_err3", 32'(e3), 32'(merr3));
            check("rnd_err4", 32'(e4), 32'h0);
            for (int k = 0; k < 4; k++)
                if (m4[k].size() > 0) check($sformatf("rnd_data4_l%0d", k), 32'(do4[k*8 +: 8]), 32'(m4[k][0]));
            for (int k = 0; k < 3; k++)
                if (m3[k].size() > 0) check($sformatf("rnd_data3_l%0d", k), 32'(do3[k*8 +: 8]), 32'(m3[k][0]));
        end

        // Asynchronous reset between clock edges, lanes partly full
        #2;
        v4 = 0; y4 = 0; v3 = 0; y3 = 0;
        reset_n = 1'b0;
        #1;
        check("areset_v_o4", 32'(vo4), 32'h0);
        check("areset_v_o3", 32'(vo3), 32'h0);
        check("areset_err3", 32'(e3), 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step4('{1'b1, 2'd2, 8'h77, 4'b0000, 1'b1, 4'b0100, 1'b1, 2, 8'h77}, "post_rst_a");
        step4('{1'b1, 2'd2, 8'h78, 4'b0000, 1'b1, 4'b0100, 1'b1, 2, 8'h77}, "post_rst_b");
        step4('{1'b1, 2'd2, 8'h79, 4'b0000, 1'b0, 4'b0100, 1'b1, 2, 8'h77}, "post_rst_c");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
